pool_stream: RTL

//  Streaming, parametrised successor to the fixed 3x3/2x2 averaging pool. Consumes CH-channel

---
 rtl/pool_pkg.sv | 23 ++
 rtl/pool_band_ram.sv | 40 ++++
 rtl/pool_stream.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared types and arithmetic helpers for the streaming KxK average/max pool.
// Used by pool_stream (optional MAX_POOL_EN build) and pool_band_ram.
package pool_pkg;

   typedef enum logic {WIN2, WIN3} win_e;
   typedef enum logic {IDLE, RUN}  state_e;

   localparam int RECIP9    = 58255;
   localparam int RECIP9_SH = 19;

   // Accumulator width: nine samples of pix_w bits need four extra bits.
   function automatic int sum_w(input int pix_w);
      return pix_w + 4;
   endfunction

   // Window-average divide: /4 by shift, /9 by reciprocal multiply (exact for 9*(2^8-1)).
   function automatic logic [31:0] div_win(input logic [31:0] sum, input win_e k);
      logic [63:0] prod;
      prod = 64'(sum) * 64'(RECIP9);
      return (k == WIN3) ? 32'(prod >> RECIP9_SH) : (sum >> 2);
   endfunction

endpackage

// File: rtl/pool_band_ram.sv
// Band accumulator store: simple dual-port, registered read, write-first bypass
// so a read of the address being written in the same cycle returns the new data.
module pool_band_ram
   import pool_pkg::*;
#(
   parameter int DEPTH = 320,
   parameter int DW    = 36,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rdata_q, rdata_d;

   // NOTE: the storage array has no reset; the first band row always overwrites it.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = (we && (waddr == raddr)) ? wdata : mem[raddr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/pool_stream.sv
// Streaming non-overlapping KxK (K=2/3 per frame) pooling over a raster pixel stream.
// Optional MAX_POOL_EN adds a `mode` input selecting per-channel max instead of average.
module pool_stream
   import pool_pkg::*;
#(
   parameter int PIX_W = 8,
   parameter int CH    = 3,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                win3,
`ifdef MAX_POOL_EN
   input  logic                mode,
`endif
   input  logic                s_valid,
   output logic                s_ready,
   input  logic                s_sof,
   input  logic [CH*PIX_W-1:0] s_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [CH*PIX_W-1:0] m_data,
   output logic                m_eol,
   output logic                frame_err
);

   localparam int SUM_W = sum_w(PIX_W);
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int DEPTH = IMG_W / 2;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] OW2      = COL_W'(IMG_W / 2);
   localparam logic [COL_W-1:0] OW3      = COL_W'(IMG_W / 3);
   localparam logic [ROW_W-1:0] OH2      = ROW_W'(IMG_H / 2);
   localparam logic [ROW_W-1:0] OH3      = ROW_W'(IMG_H / 3);

   state_e                     state_q, state_d;
   win_e                       k_q, k_d;
   logic                       max_q, max_d;
   logic [COL_W-1:0]           col_q, col_d, oc_q, oc_d;
   logic [ROW_W-1:0]           row_q, row_d, band_q, band_d;
   logic [1:0]                 kcol_q, kcol_d, krow_q, krow_d;
   logic [CH-1:0][SUM_W-1:0]   hs_q, hs_d;
   logic                       m_valid_q, m_valid_d;
   logic [CH*PIX_W-1:0]        m_data_q, m_data_d;
   logic                       m_eol_q, m_eol_d;
   logic                       frame_err_q, frame_err_d;

   logic                       accept, start, proc, start_max;
   win_e                       cur_k;
   logic                       cur_max;
   logic [COL_W-1:0]           cur_col, cur_oc, ow;
   logic [ROW_W-1:0]           cur_row, cur_band, oh;
   logic [1:0]                 cur_kcol, cur_krow, klast;
   logic                       win_ok, grp_end, win_end;
   logic                       ram_we, ram_re;
   logic [CH*SUM_W-1:0]        ram_wdata, ram_rdata;
   logic [CH*PIX_W-1:0]        out_pix;

`ifdef MAX_POOL_EN
   assign start_max = mode;
`else
   assign start_max = 1'b0;
`endif

   function automatic logic [SUM_W-1:0] combine(input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] b,
                                                 input logic             is_max);
      if (is_max) return (a > b) ? a : b;
      return a + b;
   endfunction

   assign s_ready = !m_valid_q || m_ready;
   assign accept  = s_valid && s_ready;
   assign start   = accept && s_sof;
   assign proc    = accept && (s_sof || (state_q == RUN));

   // A sof pixel is position (0,0) of a new frame whatever state we were in.
   always_comb begin
      if (start) begin
         cur_k    = win3 ? WIN3 : WIN2;
         cur_max  = start_max;
         cur_col  = '0;
         cur_oc   = '0;
         cur_row  = '0;
         cur_band = '0;
         cur_kcol = '0;
         cur_krow = '0;
      end else begin
         cur_k    = k_q;
         cur_max  = max_q;
         cur_col  = col_q;
         cur_oc   = oc_q;
         cur_row  = row_q;
         cur_band = band_q;
         cur_kcol = kcol_q;
         cur_krow = krow_q;
      end
      klast   = (cur_k == WIN3) ? 2'd2 : 2'd1;
      ow      = (cur_k == WIN3) ? OW3 : OW2;
      oh      = (cur_k == WIN3) ? OH3 : OH2;
      win_ok  = (cur_oc < ow) && (cur_band < oh);
      grp_end = (cur_kcol == klast);
      win_end = grp_end && (cur_krow == klast);
      ram_we  = proc && win_ok && grp_end;
      ram_re  = proc && win_ok && (cur_kcol == (klast - 2'd1));
   end

   always_comb begin : datapath
      logic [SUM_W-1:0] pix_v, grp_v, base_v, tot_v;
      hs_d      = hs_q;
      ram_wdata = '0;
      out_pix   = '0;
      for (int c = 0; c < CH; c++) begin
         pix_v  = SUM_W'(s_data[c*PIX_W +: PIX_W]);
         grp_v  = combine(hs_q[c], pix_v, cur_max);
         base_v = ram_rdata[c*SUM_W +: SUM_W];
         tot_v  = (cur_krow == 2'd0) ? grp_v : combine(base_v, grp_v, cur_max);
         ram_wdata[c*SUM_W +: SUM_W] = tot_v;
         out_pix[c*PIX_W +: PIX_W] = cur_max ? PIX_W'(tot_v)
                                             : PIX_W'(div_win(32'(tot_v), cur_k));
         if (proc) hs_d[c] = (cur_kcol == 2'd0) ? pix_v : grp_v;
      end
   end

   // NOTE: every output of this block gets a default first, so no latch can be inferred.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      max_d       = max_q;
      col_d       = col_q;
      oc_d        = oc_q;
      kcol_d      = kcol_q;
      row_d       = row_q;
      band_d      = band_q;
      krow_d      = krow_q;
      m_valid_d   = m_valid_q && !m_ready;
      m_data_d    = m_data_q;
      m_eol_d     = m_eol_q;
      frame_err_d = accept && (((state_q == IDLE) && !s_sof) || ((state_q == RUN) && s_sof));

      if (proc) begin
         state_d = RUN;
         k_d     = cur_k;
         max_d   = cur_max;
         row_d   = cur_row;
         band_d  = cur_band;
         krow_d  = cur_krow;
         if (cur_col == COL_LAST) begin
            col_d  = '0;
            oc_d   = '0;
            kcol_d = '0;
            if (cur_row == ROW_LAST) begin
               state_d = IDLE;
               row_d   = '0;
               band_d  = '0;
               krow_d  = '0;
            end else begin
               row_d = cur_row + ROW_W'(1);
               if (cur_krow == klast) begin
                  krow_d = '0;
                  band_d = cur_band + ROW_W'(1);
               end else begin
                  krow_d = cur_krow + 2'd1;
               end
            end
         end else begin
            col_d = cur_col + COL_W'(1);
            if (grp_end) begin
               kcol_d = '0;
               oc_d   = cur_oc + COL_W'(1);
            end else begin
               kcol_d = cur_kcol + 2'd1;
               oc_d   = cur_oc;
            end
         end

         if (win_end && win_ok) begin
            m_valid_d = 1'b1;
            m_data_d  = out_pix;
            m_eol_d   = (cur_oc == (ow - COL_W'(1)));
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         k_q         <= WIN2;
         max_q       <= 1'b0;
         col_q       <= '0;
         oc_q        <= '0;
         kcol_q      <= '0;
         row_q       <= '0;
         band_q      <= '0;
         krow_q      <= '0;
         hs_q        <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         m_eol_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         max_q       <= max_d;
         col_q       <= col_d;
         oc_q        <= oc_d;
         kcol_q      <= kcol_d;
         row_q       <= row_d;
         band_q      <= band_d;
         krow_q      <= krow_d;
         hs_q        <= hs_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         m_eol_q     <= m_eol_d;
         frame_err_q <= frame_err_d;
      end
   end

   pool_band_ram #(
      .DEPTH (DEPTH),
      .DW    (CH*SUM_W),
      .AW    (AW)
   ) u_band_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .waddr (AW'(cur_oc)),
      .wdata (ram_wdata),
      .re    (ram_re),
      .raddr (AW'(cur_oc)),
      .rdata (ram_rdata)
   );

   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign m_eol     = m_eol_q;
   assign frame_err = frame_err_q;

endmodule
